// File: rtl/fircoe_mch_wr_burst.sv
// Multi-channel FIR-coefficient DDR write burster.
// Per-channel FWFT FIFOs feed a single DDR burst-write port through a
// round-robin arbiter. A channel is served once it holds a full burst, or
// once it has sat non-empty and idle long enough to warrant a partial flush.
// Every channel keeps its own wrapping block counter and addresses its own
// DDR region.
module fircoe_mch_wr_burst #(
   parameter int                     CH_NUM       = 4,
   parameter int                     CH_W         = $clog2(CH_NUM),
   parameter int                     FIFO_DEPTH   = 32,
   parameter int                     DDR_ADDR_WD  = 32,
   parameter int                     DDR_DATA_WD  = 512,
   parameter int                     SUB_WD       = 32,
   parameter int                     SWAP         = 1,
   parameter int                     BURST_LEN    = 8,
   parameter logic [DDR_ADDR_WD-1:0] BASE_ADDR    = 32'h0,
   parameter logic [DDR_ADDR_WD-1:0] CH_STRIDE    = 32'h0100_0000,
   parameter logic [DDR_ADDR_WD-1:0] MAX_BLK_SIZE = 32'h20000,
   parameter int                     ADDR_SHIFT   = 3,
   parameter int                     TIMEOUT      = 5000
) (
   input  logic                            ddr_clk,
   input  logic                            ddr_rst_n,
   input  logic                            cfg_rst,
   input  logic [CH_NUM-1:0]               i_addr_sync,
   input  logic                            i_vld,
   input  logic [CH_W-1:0]                 i_ch,
   input  logic [DDR_DATA_WD-1:0]          i_data,
   output logic                            o_ready,
   output logic                            wr_burst_req,
   output logic [9:0]                      wr_burst_len,
   output logic [DDR_ADDR_WD-1:0]          wr_burst_addr,
   input  logic                            wr_burst_data_req,
   output logic [DDR_DATA_WD-1:0]          wr_burst_data,
   input  logic                            wr_burst_finish,
   output logic [CH_NUM*DDR_ADDR_WD-1:0]   wr_glb_blk_cnt,
   output logic                            o_busy
);

   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int LW   = PW + 1;
   localparam int TW   = $clog2(TIMEOUT + 1);
   localparam int NSUB = DDR_DATA_WD / SUB_WD;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   // ---------------------------------------------------------------------
   // Synchronisers
   // ---------------------------------------------------------------------
   logic [1:0]        cfg_sync_q;
   logic              cfg_rst_sync;
   logic [CH_NUM-1:0] as_s1_q;
   logic [CH_NUM-1:0] as_s2_q;
   logic [CH_NUM-1:0] as_s3_q;
   logic [CH_NUM-1:0] as_edge;

   assign cfg_rst_sync = cfg_sync_q[1];
   assign as_edge      = as_s2_q & ~as_s3_q;

   // Bring cfg_rst and the per-channel address-sync strobes into ddr_clk.
   always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
      if (!ddr_rst_n) begin
         cfg_sync_q <= '0;
         as_s1_q    <= '0;
         as_s2_q    <= '0;
         as_s3_q    <= '0;
      end else begin
         cfg_sync_q <= {cfg_sync_q[0], cfg_rst};
         as_s1_q    <= i_addr_sync;
         as_s2_q    <= as_s1_q;
         as_s3_q    <= as_s2_q;
      end
   end

   // ---------------------------------------------------------------------
   // FSM / arbiter state
   // ---------------------------------------------------------------------
   logic [1:0]             state_q, state_d;
   logic [CH_W-1:0]        gch_q, gch_d;
   logic [CH_W-1:0]        rr_q, rr_d;
   logic [9:0]             len_q, len_d;
   logic [9:0]             cnt_q, cnt_d;
   logic [DDR_ADDR_WD-1:0] addr_q, addr_d;
   logic                   fin_pend_q, fin_pend_d;

   // ---------------------------------------------------------------------
   // Per-channel FIFOs
   // ---------------------------------------------------------------------
   logic [DDR_DATA_WD-1:0] mem_q [CH_NUM][FIFO_DEPTH];
   logic [PW:0]            wr_ptr_q [CH_NUM];
   logic [PW:0]            rd_ptr_q [CH_NUM];
   logic [LW-1:0]          level [CH_NUM];
   logic [CH_NUM-1:0]      full;
   logic [CH_NUM-1:0]      empty;
   logic                   push;
   logic                   pop;
   logic [DDR_DATA_WD-1:0] head;

   // Derive FIFO occupancy flags from the pointer pair of each channel.
   always_comb begin
      for (int unsigned c = 0; c < CH_NUM; c++) begin
         level[c] = wr_ptr_q[c] - rd_ptr_q[c];
         full[c]  = (level[c] == LW'(FIFO_DEPTH));
         empty[c] = (level[c] == '0);
      end
   end

   assign o_ready = ~full[i_ch] & ~cfg_rst_sync;
   assign push    = i_vld & o_ready;
   assign pop     = ((state_q == S_REQ) || (state_q == S_DATA)) & wr_burst_data_req
                    & ~empty[gch_q] & ~cfg_rst_sync;
   assign head    = mem_q[gch_q][rd_ptr_q[gch_q][PW-1:0]];

   // Advance FIFO pointers on push/pop; cfg_rst empties every channel.
   always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
      if (!ddr_rst_n) begin
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
      end else if (cfg_rst_sync) begin
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (push && (i_ch == CH_W'(c)))
               wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
            if (pop && (gch_q == CH_W'(c)))
               rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
         end
      end
   end

   // Store pushed words; storage needs no reset since pointers gate reads.
   always_ff @(posedge ddr_clk) begin
      if (push)
         mem_q[i_ch][wr_ptr_q[i_ch][PW-1:0]] <= i_data;
   end

   // Present the FIFO head, optionally with its sub-word order reversed.
   always_comb begin
      wr_burst_data = head;
      if (SWAP != 0) begin
         for (int unsigned s = 0; s < NSUB; s++)
            wr_burst_data[s*SUB_WD +: SUB_WD] = head[(NSUB-1-s)*SUB_WD +: SUB_WD];
      end
   end

   // ---------------------------------------------------------------------
   // Idle timers and eligibility
   // ---------------------------------------------------------------------
   logic [TW-1:0]     tmr_q [CH_NUM];
   logic [CH_NUM-1:0] elig;

   // Count idle cycles of non-empty, non-granted channels up to TIMEOUT.
   always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
      if (!ddr_rst_n) begin
         for (int unsigned c = 0; c < CH_NUM; c++)
            tmr_q[c] <= '0;
      end else begin
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (cfg_rst_sync || empty[c] || ((state_q != S_IDLE) && (gch_q == CH_W'(c))))
               tmr_q[c] <= '0;
            else if (tmr_q[c] != TW'(TIMEOUT))
               tmr_q[c] <= tmr_q[c] + 1'b1;
         end
      end
   end

   // A channel may burst when it holds a full burst or has timed out.
   always_comb begin
      for (int unsigned c = 0; c < CH_NUM; c++)
         elig[c] = (level[c] >= LW'(BURST_LEN)) ||
                   ((tmr_q[c] == TW'(TIMEOUT)) && !empty[c]);
   end

   // ---------------------------------------------------------------------
   // Round-robin pick and burst parameter calculation
   // ---------------------------------------------------------------------
   logic                   found;
   logic [CH_W-1:0]        pick;
   logic [CH_W-1:0]        idx;
   logic [LW-1:0]          lvl_pick;
   logic [9:0]             len_calc;
   logic [DDR_ADDR_WD-1:0] blk_cnt_q [CH_NUM];
   logic [DDR_ADDR_WD-1:0] addr_calc;

   // First eligible channel at or after the round-robin pointer.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         idx = rr_q + CH_W'(i);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Length and start address of the burst the picked channel would issue.
   always_comb begin
      lvl_pick  = level[pick];
      len_calc  = (lvl_pick >= LW'(BURST_LEN)) ? 10'(BURST_LEN) : 10'(lvl_pick);
      addr_calc = BASE_ADDR + (DDR_ADDR_WD'(pick) * CH_STRIDE) +
                  ((blk_cnt_q[pick] & (MAX_BLK_SIZE - DDR_ADDR_WD'(1))) << ADDR_SHIFT);
   end

   // ---------------------------------------------------------------------
   // Burst FSM
   // ---------------------------------------------------------------------
   logic finish_now;
   assign finish_now = (state_q == S_FIN) && (wr_burst_finish || fin_pend_q) && !cfg_rst_sync;

   // Next-state logic: grant, request, stream len words, wait for finish.
   always_comb begin
      state_d    = state_q;
      gch_d      = gch_q;
      rr_d       = rr_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      fin_pend_d = fin_pend_q;
      if (cfg_rst_sync) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         fin_pend_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_d      = '0;
               fin_pend_d = 1'b0;
               if (found) begin
                  gch_d   = pick;
                  len_d   = len_calc;
                  addr_d  = addr_calc;
                  state_d = S_REQ;
               end
            end
            S_REQ: begin
               if (pop) begin
                  cnt_d   = cnt_q + 10'd1;
                  state_d = ((cnt_q + 10'd1) == len_q) ? S_FIN : S_DATA;
               end
            end
            S_DATA: begin
               // An early finish pulse is remembered and honoured in FIN.
               if (wr_burst_finish)
                  fin_pend_d = 1'b1;
               if (pop) begin
                  cnt_d = cnt_q + 10'd1;
                  if ((cnt_q + 10'd1) == len_q)
                     state_d = S_FIN;
               end
            end
            default: begin
               if (finish_now) begin
                  rr_d       = gch_q + CH_W'(1);
                  fin_pend_d = 1'b0;
                  state_d    = S_IDLE;
               end
            end
         endcase
      end
   end

   // FSM and latched burst parameters.
   always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
      if (!ddr_rst_n) begin
         state_q    <= S_IDLE;
         gch_q      <= '0;
         rr_q       <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         addr_q     <= '0;
         fin_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gch_q      <= gch_d;
         rr_q       <= rr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         fin_pend_q <= fin_pend_d;
      end
   end

   // Block counters: address-sync clear beats a coincident finish update.
   always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
      if (!ddr_rst_n) begin
         for (int unsigned c = 0; c < CH_NUM; c++)
            blk_cnt_q[c] <= '0;
      end else begin
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (cfg_rst_sync || as_edge[c])
               blk_cnt_q[c] <= '0;
            else if (finish_now && (gch_q == CH_W'(c)))
               blk_cnt_q[c] <= blk_cnt_q[c] + DDR_ADDR_WD'(len_q);
         end
      end
   end

   // Flatten block counters onto the global bus, channel 0 at the LSBs.
   always_comb begin
      wr_glb_blk_cnt = '0;
      for (int unsigned c = 0; c < CH_NUM; c++)
         wr_glb_blk_cnt[c*DDR_ADDR_WD +: DDR_ADDR_WD] = blk_cnt_q[c];
   end

   assign wr_burst_req  = (state_q == S_REQ) & ~cfg_rst_sync;
   assign wr_burst_len  = len_q;
   assign wr_burst_addr = addr_q;
   assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fircoe_mch_wr_burst.sv
// Directed scoreboard bench for fircoe_mch_wr_burst: expected words are
// queued per channel when pushed and compared when the burst port drains them.
module tb_fircoe_mch_wr_burst;

   localparam int          CH     = 4;
   localparam int          DW     = 512;
   localparam int          AW     = 32;
   localparam int          FD     = 32;
   localparam int          BL     = 8;
   localparam logic [31:0] BASE   = 32'h0;
   localparam logic [31:0] STRIDE = 32'h0100_0000;
   localparam logic [31:0] MAXB   = 32'h20;

   logic              ddr_clk = 1'b0;
   logic              ddr_rst_n;
   logic              cfg_rst;
   logic [CH-1:0]     i_addr_sync;
   logic              i_vld;
   logic [1:0]        i_ch;
   logic [DW-1:0]     i_data;
   logic              o_ready;
   logic              wr_burst_req;
   logic [9:0]        wr_burst_len;
   logic [AW-1:0]     wr_burst_addr;
   logic              wr_burst_data_req;
   logic [DW-1:0]     wr_burst_data;
   logic              wr_burst_finish;
   logic [CH*AW-1:0]  wr_glb_blk_cnt;
   logic              o_busy;

   fircoe_mch_wr_burst #(.MAX_BLK_SIZE(MAXB)) dut (
      .ddr_clk          (ddr_clk),
      .ddr_rst_n        (ddr_rst_n),
      .cfg_rst          (cfg_rst),
      .i_addr_sync      (i_addr_sync),
      .i_vld            (i_vld),
      .i_ch             (i_ch),
      .i_data           (i_data),
      .o_ready          (o_ready),
      .wr_burst_req     (wr_burst_req),
      .wr_burst_len     (wr_burst_len),
      .wr_burst_addr    (wr_burst_addr),
      .wr_burst_data_req(wr_burst_data_req),
      .wr_burst_data    (wr_burst_data),
      .wr_burst_finish  (wr_burst_finish),
      .wr_glb_blk_cnt   (wr_glb_blk_cnt),
      .o_busy           (o_busy)
   );

   always #5 ddr_clk = ~ddr_clk;

   int          errors = 0;
   int          checks = 0;
   logic [DW-1:0] exp_q [CH][$];
   logic [31:0] cnt_m [CH];
   int          cur_len;
   logic        seen;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [DW-1:0] swp(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = d[(DW/32-1-i)*32 +: 32];
      return r;
   endfunction

   function automatic logic [31:0] exp_addr(input int ch);
      return BASE + STRIDE * 32'(ch) + ((cnt_m[ch] % MAXB) << 3);
   endfunction

   task automatic push_n(input int ch, input int n);
      logic [DW-1:0] d;
      logic          exp_rdy;
      for (int k = 0; k < n; k++) begin
         @(negedge ddr_clk);
         d      = rnd();
         i_vld  = 1'b1;
         i_ch   = 2'(ch);
         i_data = d;
         #1;
         exp_rdy = (exp_q[ch].size() < FD);
         chk("o_ready_push", o_ready, exp_rdy);
         if (exp_rdy) exp_q[ch].push_back(d);
      end
      @(negedge ddr_clk);
      i_vld = 1'b0;
   endtask

   task automatic wait_grant(input int ch, input int bound);
      for (int i = 0; i < bound && wr_burst_req !== 1'b1; i++) @(negedge ddr_clk);
      chk("burst_req", wr_burst_req, 1'b1);
      cur_len = (exp_q[ch].size() >= BL) ? BL : exp_q[ch].size();
      chk("burst_len", wr_burst_len, cur_len);
      chk("burst_addr", wr_burst_addr, exp_addr(ch));
      chk("busy_grant", o_busy, 1'b1);
   endtask

   task automatic data_steps(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge ddr_clk);
         if (k == 1) chk("req_low_after_first", wr_burst_req, 1'b0);
         wr_burst_data_req = 1'b1;
         chk("burst_data", wr_burst_data, swp(exp_q[ch][0]));
         void'(exp_q[ch].pop_front());
      end
   endtask

   task automatic finish_burst(input int ch);
      data_steps(ch, cur_len);
      @(negedge ddr_clk);
      wr_burst_data_req = 1'b0;
      chk("req_low_fin", wr_burst_req, 1'b0);
      wr_burst_finish = 1'b1;
      @(negedge ddr_clk);
      wr_burst_finish = 1'b0;
      cnt_m[ch] = cnt_m[ch] + 32'(cur_len);
      chk("blk_cnt", wr_glb_blk_cnt[ch*AW +: AW], cnt_m[ch]);
      chk("busy_idle", o_busy, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      ddr_rst_n = 1'b0; cfg_rst = 1'b0; i_addr_sync = '0; i_vld = 1'b0;
      i_ch = '0; i_data = '0; wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
      for (int c = 0; c < CH; c++) cnt_m[c] = '0;

      // Reset state
      repeat (3) @(negedge ddr_clk);
      chk("rst_req", wr_burst_req, 1'b0);
      chk("rst_len", wr_burst_len, 10'd0);
      chk("rst_addr", wr_burst_addr, 32'd0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_blk", wr_glb_blk_cnt, '0);
      chk("rst_ready", o_ready, 1'b1);
      ddr_rst_n = 1'b1;
      repeat (2) @(negedge ddr_clk);

      // Full burst on ch2
      push_n(2, 8);
      wait_grant(2, 20);
      finish_burst(2);

      // Partial burst on ch1 after the idle timeout
      push_n(1, 3);
      seen = 1'b0;
      repeat (4900) begin
         @(negedge ddr_clk);
         if (wr_burst_req === 1'b1) seen = 1'b1;
      end
      chk("no_early_req", seen, 1'b0);
      wait_grant(1, 400);
      finish_burst(1);

      // Round robin: ch3 busy while ch0 fills; pointer 0 then serves ch0 first
      push_n(3, 16);
      wait_grant(3, 20);
      push_n(0, 8);
      finish_burst(3);
      wait_grant(0, 20);
      finish_burst(0);
      wait_grant(3, 20);
      finish_burst(3);

      // Round robin: pointer 1 serves ch3 ahead of ch0
      push_n(0, 16);
      wait_grant(0, 20);
      push_n(3, 8);
      finish_burst(0);
      wait_grant(3, 20);
      finish_burst(3);
      wait_grant(0, 20);
      finish_burst(0);

      // Block-count wrap on ch0 (count now MAXB-8)
      chk("pre_wrap_cnt", wr_glb_blk_cnt[0 +: AW], MAXB - 32'd8);
      push_n(0, 16);
      wait_grant(0, 20);
      finish_burst(0);
      wait_grant(0, 20);
      chk("wrap_addr", wr_burst_addr, BASE);
      finish_burst(0);
      chk("wrap_cnt", wr_glb_blk_cnt[0 +: AW], MAXB + 32'd8);

      // Full FIFO on ch1 blocks only ch1; the rejected word is not stored
      push_n(1, 32);
      @(negedge ddr_clk);
      i_ch = 2'd1; #1;
      chk("full_ready_ch1", o_ready, 1'b0);
      i_ch = 2'd2; #1;
      chk("full_ready_ch2", o_ready, 1'b1);
      push_n(1, 1);
      for (int b = 0; b < 4; b++) begin
         wait_grant(1, 20);
         finish_burst(1);
      end
      seen = 1'b0;
      repeat (5100) begin
         @(negedge ddr_clk);
         if (wr_burst_req === 1'b1) seen = 1'b1;
      end
      chk("no_stray_word", seen, 1'b0);

      // cfg_rst mid-burst
      push_n(2, 8);
      wait_grant(2, 20);
      data_steps(2, 4);
      @(negedge ddr_clk);
      wr_burst_data_req = 1'b0;
      cfg_rst = 1'b1;
      repeat (3) @(negedge ddr_clk);
      i_ch = 2'd2; #1;
      chk("cfg_req", wr_burst_req, 1'b0);
      chk("cfg_busy", o_busy, 1'b0);
      chk("cfg_blk", wr_glb_blk_cnt, '0);
      chk("cfg_ready", o_ready, 1'b0);
      for (int c = 0; c < CH; c++) begin
         exp_q[c].delete();
         cnt_m[c] = '0;
      end
      cfg_rst = 1'b0;
      repeat (3) @(negedge ddr_clk);
      #1;
      chk("cfg_release_ready", o_ready, 1'b1);

      // Fresh burst on ch2 (flushed words must not reappear), then an
      // address-sync edge coincident with its finish clears the counter
      push_n(2, 8);
      wait_grant(2, 20);
      data_steps(2, 8);
      @(negedge ddr_clk);
      wr_burst_data_req = 1'b0;
      i_addr_sync = 4'b0100;
      @(negedge ddr_clk);
      @(negedge ddr_clk);
      wr_burst_finish = 1'b1;
      @(negedge ddr_clk);
      wr_burst_finish = 1'b0;
      i_addr_sync = '0;
      cnt_m[2] = '0;
      chk("sync_over_finish", wr_glb_blk_cnt[2*AW +: AW], cnt_m[2]);
      chk("sync_busy", o_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fircoe_mch_wr_burst.md
Name: fircoe_mch_wr_burst

Overview:
Multi-channel successor of the single-stream FIR-coefficient DDR write burster.
- Accepts DDR-width coefficient words tagged with a channel id and buffers them in per-channel synchronous FIFOs.
- Round-robin arbitrates full or timed-out channels onto one DDR burst-write port.
- Issues variable-length (partial) bursts on timeout.
- Keeps an independent wrapping block counter per channel; each channel owns its own DDR region.

Parameters:
- CH_NUM, 4, number of channels (power of 2, >=2)
- CH_W, $clog2(CH_NUM), channel id width
- FIFO_DEPTH, 32, words per channel FIFO (power of 2)
- DDR_ADDR_WD, 32, DDR address width
- DDR_DATA_WD, 512, DDR data width
- SUB_WD, 32, sub-word width for order swap
- SWAP, 1, 1 = reverse SUB_WD sub-word order on wr_burst_data
- BURST_LEN, 8, full burst length in words (<= FIFO_DEPTH)
- BASE_ADDR, 32'h0, region base of channel 0
- CH_STRIDE, 32'h0100_0000, address offset between channel regions
- MAX_BLK_SIZE, 32'h20000, block-count wrap modulus (power of 2)
- ADDR_SHIFT, 3, left shift from block count to DDR address
- TIMEOUT, 5000, idle cycles before a partial flush

Ports:
- ddr_clk, in, 1, clock
- ddr_rst_n, in, 1, async active-low reset
- cfg_rst, in, 1, async level; flush and clear; 2-flop synchronised internally
- i_addr_sync, in, CH_NUM, per-channel counter clear; rising edge detected after 2-flop sync
- i_vld, in, 1, input word valid
- i_ch, in, CH_W, input channel id
- i_data, in, DDR_DATA_WD, input word
- o_ready, out, 1, = ~full[i_ch] & ~cfg_rst_sync; combinational
- wr_burst_req, out, 1, burst request
- wr_burst_len, out, 10, burst length in words
- wr_burst_addr, out, DDR_ADDR_WD, burst start address
- wr_burst_data_req, in, 1, controller pops one word
- wr_burst_data, out, DDR_DATA_WD, FWFT head of granted FIFO, optionally swapped
- wr_burst_finish, in, 1, one-cycle burst completion pulse
- wr_glb_blk_cnt, out, CH_NUM*DDR_ADDR_WD, per-channel block counters, ch0 at LSBs
- o_busy, out, 1, FSM not in IDLE

Behaviour:
- Reset (ddr_rst_n=0): all FIFOs empty, FSM IDLE, rr pointer 0, all blk_cnt 0, all timers 0. wr_burst_req=0, wr_burst_len=0, wr_burst_addr=0, o_busy=0.
- Write: i_vld & o_ready pushes i_data into FIFO[i_ch]. i_vld with o_ready=0 is ignored; the source holds the word.
- Timer[c]: clears when FIFO[c] is empty, when c is granted, or on cfg_rst. Otherwise increments, saturating at TIMEOUT.
- Eligible[c] = level[c] >= BURST_LEN, or (timer[c] == TIMEOUT and level[c] != 0).
- FSM IDLE:
  - If any channel is eligible, grant the first eligible channel at or after the rr pointer.
  - Latch gch, len = min(level, BURST_LEN), addr = BASE_ADDR + gch*CH_STRIDE + ((blk_cnt[gch] & (MAX_BLK_SIZE-1)) << ADDR_SHIFT).
  - Go to REQ next cycle.
- REQ: wr_burst_req=1; len and addr stay stable. On the first wr_burst_data_req go to DATA; that cycle pops word 1.
- DATA:
  - Each wr_burst_data_req pops FIFO[gch] (data_req with gch FIFO empty is ignored).
  - After len pops go to FIN.
  - wr_burst_req deasserts on the cycle of the first data_req.
- FIN:
  - On wr_burst_finish: blk_cnt[gch] += len (DDR_ADDR_WD wrap); rr = gch+1 mod CH_NUM; go to IDLE.
  - A finish pulse that arrives during DATA is held and applied on entering FIN.
- wr_burst_len/addr hold their last granted values outside REQ.
- Simultaneous push and pop on the same FIFO: level unchanged, data order preserved.
- Push into a non-granted channel during a burst is allowed.
- Pop latency is 0: wr_burst_data shows the next head in the cycle after the pop.
- A FIFO holding FIFO_DEPTH words is full: o_ready=0 for that id.
- i_addr_sync edge on channel c: blk_cnt[c] <= 0, taking priority over a coincident finish update on c.
- cfg_rst_sync high, including mid-burst:
  - FIFOs flushed, all blk_cnt and timers cleared, FSM forced to IDLE, wr_burst_req=0.
  - Held while high; no grants.
  - The controller must abort its burst.
- Swap (SWAP=1): output sub-word i takes input sub-word (DDR_DATA_WD/SUB_WD-1-i).

Test Plan:
- Reset then push 8 words to ch2 -> single burst: req, len=8, addr=BASE_ADDR+2*CH_STRIDE; 8 words in order; after finish blk_cnt[2]=8.
- Push 3 words to ch1, wait TIMEOUT=5000 cycles -> burst with len=3, addr=BASE_ADDR+CH_STRIDE; blk_cnt[1]=3; no burst before timeout.
- ch0 and ch3 both hold >=8 words, rr=0 -> ch0 burst then ch3; repeat with rr=1 -> ch3 served first.
- Preload blk_cnt[0]=MAX_BLK_SIZE-8, do 2 bursts -> second addr=BASE_ADDR+0; wr_glb_blk_cnt ch0=MAX_BLK_SIZE+8.
- Fill ch1 to 32 words -> o_ready=0 for i_ch=1, o_ready=1 for i_ch=2; a push with i_ch=1 is not stored.
- cfg_rst asserted after 4 of 8 data_req -> req low, FIFOs empty, blk_cnt all 0, o_busy=0; i_addr_sync[2] edge coincident with ch2 finish -> blk_cnt[2]=0.
